fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
//  Round-robin arbiter sharing one combinational fp_adder (IEEE-754 single, A+B->Out) among NUM_REQ requesters.
//  Captures the winning operand pair, drives the adder for one settle cycle, and registers the sum.
//  Returns the sum tagged with the requester index through a valid/ready response channel.
//  Sits between FP-using client blocks and the single fp_adder instance; the adder itself is external.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ID_W     2   width of requester index; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  req_valid    in   NUM_REQ     per-requester operand-pair valid
//  req_a        in   32*NUM_REQ  operand A; requester i on bits [32*i+31:32*i]
//  req_b        in   32*NUM_REQ  operand B; same packing as req_a
//  req_ready    out  NUM_REQ     one-hot grant; transfer when req_valid[i] & req_ready[i]
//  add_a        out  32          operand A to fp_adder
//  add_b        out  32          operand B to fp_adder
//  add_out      in   32          fp_adder sum, combinational from add_a/add_b
//  resp_valid   out  1           result available
//  resp_id      out  ID_W        index of the requester that owns resp_data
//  resp_data    out  32          registered sum
//  resp_ready   in   1           consumer accepts the result
//  op_count     out  16          completed operations; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE. Reset state is IDLE.
//  - Reset values: req_ready=0, add_a=add_b=0, resp_valid=0, resp_id=0, resp_data=0, op_count=0, rr_ptr=0.
//  - Reset asserted mid-operation aborts the operation at once; the in-flight result is discarded, with no response.
//  - IDLE: winner = first i with req_valid[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
//    req_ready is driven one-hot to the winner, combinationally from req_valid and rr_ptr, and only in IDLE.
//    req_ready is 0 in all other states and 0 when no request is valid.
//  - Requesters must not make req_valid depend on req_ready.
//  - Once asserted, req_valid and its operands hold until the transfer completes.
//  - On transfer (cycle t): latch req_a/req_b of the winner into add_a/add_b and the winner index into resp_id.
//    Set rr_ptr = (winner+1) mod NUM_REQ, then go to ISSUE.
//  - ISSUE (cycle t+1): add_a/add_b are stable; at the end of the cycle resp_data <= add_out and resp_valid <= 1.
//    Next state is RESP.
//  - RESP (from t+2): resp_valid, resp_id and resp_data hold stable until resp_ready=1.
//    On the handshake: resp_valid <= 0, op_count <= op_count+1 (mod 2**16), go to IDLE.
//  - Latency from request accept to resp_valid is 2 cycles. Best-case throughput is 1 op per 3 cycles.
//    There is no grant in the RESP->IDLE transition cycle.
//  - Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid high and are served in rotation.
//    No requester waits more than NUM_REQ-1 other operations.
//  - resp_ready asserted outside RESP is ignored.
//  - add_a/add_b hold their last value in IDLE, so the adder does not toggle.
//  - Arithmetic, rounding and special values are entirely those of fp_adder; the arbiter never modifies data.
// TESTING
//  1 Single request: req0 A=0x40200000 (2.5), B=0x3F000000 (0.5).
//    -> req_ready[0] same cycle; resp_valid 2 cycles later; resp_data=0x40400000; resp_id=0.
//  2 Req2 A=0x42C80000 (100), B=0x41B80000 (23).
//    -> resp_data=0x42F60000, resp_id=2, op_count increments by 1.
//  3 All 4 requesters valid from reset, resp_ready tied 1.
//    -> grants in order 0,1,2,3,0; each resp_id matches its grant; one grant every 3 cycles.
//  4 Backpressure: resp_ready=0 for 5 cycles while req1 is valid.
//    -> resp_valid/resp_data/resp_id stable; req_ready stays 0; req1 granted in IDLE after the handshake.
//  5 Assert rst_n=0 in ISSUE.
//    -> all outputs return to reset values immediately; no response; next grant starts from requester 0.
//  6 Preload op_count=0xFFFF via 65535 ops (or force), then one more op -> op_count=0x0000.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin front end for one shared, external,
// combinational fp_adder. A winning requester's operand pair is latched
// onto the adder inputs. The adder settles for one cycle. The sum is then
// registered and returned, tagged with the requester index, over a
// valid/ready response channel.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic [31:0]            add_out,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_data,
  input  logic                   resp_ready,
  output logic [15:0]            op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]         add_a_q, add_a_d;
  logic [31:0]         add_b_q, add_b_d;
  logic                resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic [15:0]         op_count_q, op_count_d;

  logic                found;
  int                  idx;
  int                  winner;
  logic [NUM_REQ-1:0]  grant_vec;
  logic [31:0]         sel_a;
  logic [31:0]         sel_b;

  // Rotating priority scan: the first valid requester at or after rr_ptr wins
  always_comb begin
    found     = 1'b0;
    idx       = 0;
    winner    = 0;
    grant_vec = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        winner         = idx;
        grant_vec[idx] = 1'b1;
        sel_a          = req_a[32*idx +: 32];
        sel_b          = req_b[32*idx +: 32];
      end
    end
  end

  // Next-state and grant logic; grants are issued only while IDLE
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = grant_vec;
          add_a_d   = sel_a;
          add_b_d   = sel_b;
          resp_id_d = ID_W'(winner);
          rr_ptr_d  = ID_W'((winner + 1) % NUM_REQ);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        resp_data_d  = add_out;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      op_count_q   <= op_count_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed bench for fp_add_arbiter. The shared adder
// is modelled by a small table holding the operand pairs used here.
// Any pair that is not in the table yields a distinctive non-sum.
module tb_fp_add_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [31:0]  add_out;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic         resp_ready;
  logic [15:0]  op_count;

  int tests_run;
  int tests_failed;

  // Operands for the round-robin set: 1+1, 2+2, 1+2, 4+4
  localparam logic [127:0] RR_A = {32'h40800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] RR_B = {32'h40800000, 32'h40000000, 32'h40000000, 32'h3F800000};
  localparam logic [31:0]  SUM0 = 32'h40000000;
  localparam logic [31:0]  SUM1 = 32'h40800000;
  localparam logic [31:0]  SUM2 = 32'h40400000;
  localparam logic [31:0]  SUM3 = 32'h41000000;

  fp_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_out    (add_out),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .op_count   (op_count)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Table-based stand-in for the external combinational adder
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40200000, 32'h3F000000}: fp_model = 32'h40400000;
      {32'h42C80000, 32'h41B80000}: fp_model = 32'h42F60000;
      {32'h3F800000, 32'h3F800000}: fp_model = 32'h40000000;
      {32'h40000000, 32'h40000000}: fp_model = 32'h40800000;
      {32'h3F800000, 32'h40000000}: fp_model = 32'h40400000;
      {32'h40800000, 32'h40800000}: fp_model = 32'h41000000;
      default:                      fp_model = a ^ b ^ 32'h00C0FFEE;
    endcase
  endfunction

  always_comb add_out = fp_model(add_a, add_b);

  // Time limit so a stuck run still reports
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] timeout");
  end

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests_run++; if (add_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_add_a: got %h expected 0", add_a); end
    tests_run++; if (add_b !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_add_b: got %h expected 0", add_b); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (resp_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", resp_id); end
    tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_resp_data: got %h expected 0", resp_data); end
    tests_run++; if (op_count !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_op_count: got %h expected 0", op_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid      = 4'b0001;
    req_a[31:0]    = 32'h40200000;
    req_b[31:0]    = 32'h3F000000;
    resp_ready     = 1'b0;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL single_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL single_issue_ready: got %b expected 0000", req_ready); end
    tests_run++; if (add_a !== 32'h40200000) begin tests_failed++; $display("[TB] FAIL single_add_a: got %h expected 40200000", add_a); end
    tests_run++; if (add_b !== 32'h3F000000) begin tests_failed++; $display("[TB] FAIL single_add_b: got %h expected 3f000000", add_b); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_early_valid: got %b expected 0", resp_valid); end
    @(negedge clk);
    #1;
    tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_resp_valid: got %b expected 1", resp_valid); end
    tests_run++; if (resp_data !== 32'h40400000) begin tests_failed++; $display("[TB] FAIL single_resp_data: got %h expected 40400000", resp_data); end
    tests_run++; if (resp_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL single_resp_id: got %0d expected 0", resp_id); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_resp_drop: got %b expected 0", resp_valid); end
    tests_run++; if (op_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL single_op_count: got %0d expected 1", op_count); end
    tests_run++; if (add_a !== 32'h40200000) begin tests_failed++; $display("[TB] FAIL single_add_a_hold: got %h expected 40200000", add_a); end
  endtask

  task automatic test_req2();
    @(negedge clk);
    req_valid     = 4'b0100;
    req_a[95:64]  = 32'h42C80000;
    req_b[95:64]  = 32'h41B80000;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL req2_grant: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    tests_run++; if (resp_data !== 32'h42F60000) begin tests_failed++; $display("[TB] FAIL req2_resp_data: got %h expected 42f60000", resp_data); end
    tests_run++; if (resp_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL req2_resp_id: got %0d expected 2", resp_id); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    tests_run++; if (op_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL req2_op_count: got %0d expected 2", op_count); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_id [5];
    logic [31:0] exp_sum [4];
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum = '{SUM0, SUM1, SUM2, SUM3};
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    req_valid  = 4'b1111;
    req_a      = RR_A;
    req_b      = RR_B;
    resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      tests_run++; if (req_ready !== (4'b0001 << exp_id[n])) begin tests_failed++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", n, req_ready, 4'b0001 << exp_id[n]); end
      @(negedge clk);
      #1;
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rr_issue_ready_%0d: got %b expected 0000", n, req_ready); end
      @(negedge clk);
      #1;
      tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_resp_valid_%0d: got %b expected 1", n, resp_valid); end
      tests_run++; if (resp_id !== exp_id[n]) begin tests_failed++; $display("[TB] FAIL rr_resp_id_%0d: got %0d expected %0d", n, resp_id, exp_id[n]); end
      tests_run++; if (resp_data !== exp_sum[exp_id[n]]) begin tests_failed++; $display("[TB] FAIL rr_resp_data_%0d: got %h expected %h", n, resp_data, exp_sum[exp_id[n]]); end
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rr_resp_ready_%0d: got %b expected 0000", n, req_ready); end
      @(negedge clk);
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    #1;
    tests_run++; if (op_count !== 16'd5) begin tests_failed++; $display("[TB] FAIL rr_op_count: got %0d expected 5", op_count); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid  = 4'b0001;
    resp_ready = 1'b0;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL bp_grant0: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_hold_valid_%0d: got %b expected 1", n, resp_valid); end
      tests_run++; if (resp_data !== SUM0) begin tests_failed++; $display("[TB] FAIL bp_hold_data_%0d: got %h expected %h", n, resp_data, SUM0); end
      tests_run++; if (resp_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL bp_hold_id_%0d: got %0d expected 0", n, resp_id); end
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL bp_hold_ready_%0d: got %b expected 0000", n, req_ready); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_resp_drop: got %b expected 0", resp_valid); end
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL bp_grant1: got %b expected 0010", req_ready); end
    tests_run++; if (op_count !== 16'd6) begin tests_failed++; $display("[TB] FAIL bp_op_count6: got %0d expected 6", op_count); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    tests_run++; if (resp_id !== 2'd1) begin tests_failed++; $display("[TB] FAIL bp_resp_id1: got %0d expected 1", resp_id); end
    tests_run++; if (resp_data !== SUM1) begin tests_failed++; $display("[TB] FAIL bp_resp_data1: got %h expected %h", resp_data, SUM1); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    tests_run++; if (op_count !== 16'd7) begin tests_failed++; $display("[TB] FAIL bp_op_count7: got %0d expected 7", op_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("[TB] FAIL rst_pre_grant: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    tests_run++; if (add_a !== 32'h40000000) begin tests_failed++; $display("[TB] FAIL rst_issue_add_a: got %h expected 40000000", add_a); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rst_mid_req_ready: got %b expected 0000", req_ready); end
    tests_run++; if (add_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_add_a: got %h expected 0", add_a); end
    tests_run++; if (add_b !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_add_b: got %h expected 0", add_b); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (resp_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL rst_mid_resp_id: got %0d expected 0", resp_id); end
    tests_run++; if (resp_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_resp_data: got %h expected 0", resp_data); end
    tests_run++; if (op_count !== 16'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_op_count: got %h expected 0", op_count); end
    @(negedge clk);
    #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_no_response: got %b expected 0", resp_valid); end
    rst_n      = 1'b1;
    req_valid  = 4'b0101;
    resp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("[TB] FAIL rst_ptr_restart: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    #1;
    tests_run++; if (resp_id !== 2'd0) begin tests_failed++; $display("[TB] FAIL rst_after_id0: got %0d expected 0", resp_id); end
    tests_run++; if (resp_data !== SUM0) begin tests_failed++; $display("[TB] FAIL rst_after_data0: got %h expected %h", resp_data, SUM0); end
    @(negedge clk);
    #1;
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_after_drop: got %b expected 0", resp_valid); end
    tests_run++; if (op_count !== 16'd1) begin tests_failed++; $display("[TB] FAIL rst_after_count1: got %0d expected 1", op_count); end
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("[TB] FAIL rst_after_grant2: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    tests_run++; if (resp_id !== 2'd2) begin tests_failed++; $display("[TB] FAIL rst_after_id2: got %0d expected 2", resp_id); end
    tests_run++; if (resp_data !== SUM2) begin tests_failed++; $display("[TB] FAIL rst_after_data2: got %h expected %h", resp_data, SUM2); end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    tests_run++; if (op_count !== 16'd2) begin tests_failed++; $display("[TB] FAIL rst_after_count2: got %0d expected 2", op_count); end
  endtask

  task automatic test_wrap();
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.op_count_q;
    #1;
    tests_run++; if (op_count !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL wrap_preload: got %h expected ffff", op_count); end
    req_valid  = 4'b1000;
    resp_ready = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("[TB] FAIL wrap_grant3: got %b expected 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    tests_run++; if (resp_id !== 2'd3) begin tests_failed++; $display("[TB] FAIL wrap_resp_id: got %0d expected 3", resp_id); end
    tests_run++; if (resp_data !== SUM3) begin tests_failed++; $display("[TB] FAIL wrap_resp_data: got %h expected %h", resp_data, SUM3); end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    tests_run++; if (op_count !== 16'h0000) begin tests_failed++; $display("[TB] FAIL wrap_op_count: got %h expected 0000", op_count); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_resp_drop: got %b expected 0", resp_valid); end
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_req2();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
